// File: rtl/stack_pkg.sv
// Shared types and defaults for the stack sequencer.
// FSM state enum, push/pop op encoding, default stack bounds.
package stack_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PUSH_WR = 2'd1,
    S_POP_RD  = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic [15:0] STACK_BASE_DEF  = 16'hFFFF;
  localparam logic [15:0] STACK_LIMIT_DEF = 16'hFF00;

endpackage

// File: rtl/stack_ctrl.sv
// Stack sequencer: runs push/pop memory accesses, keeps a shadow SP,
// and strobes sp_push/sp_pop with sp_new_val to the SP register.
// Ports: clk/reset (sync, active-high); req_* request handshake;
// rsp_* completion; mem_* data-memory port; sp_* SP-register strobes;
// sp/empty/full shadow state.
// Macro STACK_CTRL_GUARD_EN: enables overflow/underflow guards and full.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] STACK_BASE  = ADDR_W'(STACK_BASE_DEF),
  parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(STACK_LIMIT_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              sp_push,
  output logic              sp_pop,
  output logic [ADDR_W-1:0] sp_new_val,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full
);

  if (STACK_LIMIT == '0) begin : g_limit_chk
    $error("STACK_LIMIT must be nonzero");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              spush_q, spush_d;
  logic              spop_q, spop_d;
  logic [ADDR_W-1:0] nv_q, nv_d;
  logic [ADDR_W-1:0] sp_inc, sp_dec;
  logic              accept;
  logic              guard_err;

  assign sp_inc = sp_q + 1'b1;
  assign sp_dec = sp_q - 1'b1;
  assign accept = (state_q == S_IDLE) && req_valid;

  assign req_ready  = (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_rdata  = rdata_q;
  assign sp_push    = spush_q;
  assign sp_pop     = spop_q;
  assign sp_new_val = nv_q;
  assign sp         = sp_q;
  assign empty      = (sp_q == STACK_BASE);

`ifdef STACK_CTRL_GUARD_EN
  localparam logic [ADDR_W-1:0] FULL_SP = STACK_LIMIT - 1'b1;
  logic err_q;

  assign full      = (sp_q == FULL_SP);
  assign guard_err = (req_op == OP_POP) ? empty : full;
  assign rsp_err   = rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= guard_err;
    end
  end
`else
  assign full      = 1'b0;
  assign guard_err = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    rdata_d   = rdata_q;
    spush_d   = 1'b0;
    spop_d    = 1'b0;
    nv_d      = nv_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (guard_err)             state_d = S_RESP;
          else if (req_op == OP_POP) state_d = S_POP_RD;
          else                       state_d = S_PUSH_WR;
        end
      end
      S_PUSH_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q;
        mem_wdata = wdata_q;
        if (mem_ack) begin
          sp_d    = sp_dec;
          spush_d = 1'b1;
          nv_d    = sp_dec;
          state_d = S_RESP;
        end
      end
      S_POP_RD: begin
        mem_req  = 1'b1;
        mem_addr = sp_inc;
        if (mem_ack) begin
          rdata_d = mem_rdata;
          sp_d    = sp_inc;
          spop_d  = 1'b1;
          nv_d    = sp_inc;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= STACK_BASE;
      wdata_q <= '0;
      rdata_q <= '0;
      spush_q <= 1'b0;
      spop_q  <= 1'b0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      rdata_q <= rdata_d;
      spush_q <= spush_d;
      spop_q  <= spop_d;
      nv_q    <= nv_d;
      if (accept) wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl with a behavioural memory
// that acks after a programmable number of wait cycles.
module tb_stack_ctrl;

`ifdef STACK_CTRL_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_op;
  logic [15:0] req_wdata;
  logic        req_ready;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        sp_push;
  logic        sp_pop;
  logic [15:0] sp_new_val;
  logic [15:0] sp;
  logic        empty;
  logic        full;

  int n_cmp;
  int n_bad;

  logic [15:0] mem [0:65535];
  int ack_dly;
  int wait_cnt;

  int          o_lat;
  logic        o_req1, o_we1;
  logic [15:0] o_addr1, o_wd1;
  logic        o_err, o_spush, o_spop, o_rdy;
  logic [15:0] o_rd, o_nv;

  stack_ctrl #(
    .DATA_W(16),
    .ADDR_W(16),
    .STACK_BASE(16'hFFFF),
    .STACK_LIMIT(16'hFFFC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .sp_push(sp_push),
    .sp_pop(sp_pop),
    .sp_new_val(sp_new_val),
    .sp(sp),
    .empty(empty),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        wait_cnt  = 0;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    ack_dly = 0;
  endtask

  task automatic xact(input logic op, input logic [15:0] d);
    req_valid = 1'b1;
    req_op    = op;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_wdata = 16'h0;
    o_req1  = mem_req;
    o_we1   = mem_we;
    o_addr1 = mem_addr;
    o_wd1   = mem_wdata;
    o_lat   = 1;
    while (!rsp_valid && o_lat < 40) begin
      @(posedge clk);
      #1;
      o_lat++;
    end
    if (!rsp_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL xact_timeout got no rsp_valid want one in 40 cycles");
    end
    o_err   = rsp_err;
    o_rd    = rsp_rdata;
    o_spush = sp_push;
    o_spop  = sp_pop;
    o_nv    = sp_new_val;
    @(posedge clk);
    #1;
    o_rdy = req_ready;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (sp !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL reset_sp got %h want ffff", sp);
    end
    n_cmp++;
    if ({empty, full, req_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 101", {empty, full, req_ready});
    end
    n_cmp++;
    if ({rsp_valid, rsp_err, mem_req, mem_we, sp_push, sp_pop} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 000000",
        {rsp_valid, rsp_err, mem_req, mem_we, sp_push, sp_pop});
    end
    n_cmp++;
    if ({rsp_rdata, sp_new_val, mem_addr} !== 48'h0) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0", {rsp_rdata, sp_new_val, mem_addr});
    end
    reset   = 1'b0;
    ack_dly = 0;
  endtask

  task automatic test_push_imm();
    do_reset();
    xact(1'b0, 16'hA5A5);
    n_cmp++;
    if ({o_req1, o_we1, o_addr1, o_wd1} !== {2'b11, 16'hFFFF, 16'hA5A5}) begin
      n_bad++;
      $display("FAIL push_mem got %b%b %h %h want 11 ffff a5a5",
        o_req1, o_we1, o_addr1, o_wd1);
    end
    n_cmp++;
    if (o_lat !== 2) begin
      n_bad++;
      $display("FAIL push_lat got %0d want 2", o_lat);
    end
    n_cmp++;
    if ({o_spush, o_spop, o_nv, o_err} !== {2'b10, 16'hFFFE, 1'b0}) begin
      n_bad++;
      $display("FAIL push_strobe got %b%b %h %b want 10 fffe 0",
        o_spush, o_spop, o_nv, o_err);
    end
    n_cmp++;
    if (o_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL push_ready3 got %b want 1", o_rdy);
    end
    n_cmp++;
    if (mem[16'hFFFF] !== 16'hA5A5 || sp !== 16'hFFFE) begin
      n_bad++;
      $display("FAIL push_state got mem %h sp %h want a5a5 fffe",
        mem[16'hFFFF], sp);
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    xact(1'b0, 16'h1111);
    xact(1'b0, 16'h2222);
    xact(1'b1, 16'h0000);
    n_cmp++;
    if ({o_addr1, o_rd, o_spop, o_nv} !== {16'hFFFE, 16'h2222, 1'b1, 16'hFFFE}) begin
      n_bad++;
      $display("FAIL pop1 got addr %h rd %h spop %b nv %h want fffe 2222 1 fffe",
        o_addr1, o_rd, o_spop, o_nv);
    end
    xact(1'b1, 16'h0000);
    n_cmp++;
    if ({o_addr1, o_rd, o_spop, o_nv} !== {16'hFFFF, 16'h1111, 1'b1, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL pop2 got addr %h rd %h spop %b nv %h want ffff 1111 1 ffff",
        o_addr1, o_rd, o_spop, o_nv);
    end
    n_cmp++;
    if (sp !== 16'hFFFF || empty !== 1'b1) begin
      n_bad++;
      $display("FAIL pop_empty got sp %h empty %b want ffff 1", sp, empty);
    end
    xact(1'b0, 16'h3333);
    n_cmp++;
    if (rsp_rdata !== 16'h1111) begin
      n_bad++;
      $display("FAIL rdata_hold got %h want 1111", rsp_rdata);
    end
  endtask

  task automatic test_pop_empty();
    do_reset();
    xact(1'b1, 16'h0000);
    n_cmp++;
    if (o_lat !== (GUARD ? 1 : 2) || o_err !== GUARD) begin
      n_bad++;
      $display("FAIL empty_pop_rsp got lat %0d err %b want %0d %b",
        o_lat, o_err, GUARD ? 1 : 2, GUARD);
    end
    n_cmp++;
    if (o_req1 !== !GUARD) begin
      n_bad++;
      $display("FAIL empty_pop_req got %b want %b", o_req1, !GUARD);
    end
    n_cmp++;
    if (sp !== (GUARD ? 16'hFFFF : 16'h0000) || o_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_pop_sp got sp %h rdy %b want %h 1",
        sp, o_rdy, GUARD ? 16'hFFFF : 16'h0000);
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 4; i++) xact(1'b0, 16'h00A0 + 16'(i));
    n_cmp++;
    if (sp !== 16'hFFFB || full !== GUARD || empty !== 1'b0) begin
      n_bad++;
      $display("FAIL fill4 got sp %h full %b empty %b want fffb %b 0",
        sp, full, empty, GUARD);
    end
    xact(1'b0, 16'h00A4);
    n_cmp++;
    if (o_err !== GUARD || o_lat !== (GUARD ? 1 : 2)) begin
      n_bad++;
      $display("FAIL push5_rsp got err %b lat %0d want %b %0d",
        o_err, o_lat, GUARD, GUARD ? 1 : 2);
    end
    n_cmp++;
    if (sp !== (GUARD ? 16'hFFFB : 16'hFFFA) || o_spush !== !GUARD) begin
      n_bad++;
      $display("FAIL push5_sp got sp %h spush %b want %h %b",
        sp, o_spush, GUARD ? 16'hFFFB : 16'hFFFA, !GUARD);
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    ack_dly   = 3;
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_wdata = 16'hBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 16'h0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, rsp_valid} !==
          {2'b11, 16'hFFFF, 16'hBEEF, 1'b0}) begin
        n_bad++;
        $display("FAIL ackdly_hold c%0d got %b%b %h %h rv %b want 11 ffff beef 0",
          c, mem_req, mem_we, mem_addr, mem_wdata, rsp_valid);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if ({rsp_valid, sp_push, sp} !== {2'b11, 16'hFFFE}) begin
      n_bad++;
      $display("FAIL ackdly_rsp5 got rv %b spush %b sp %h want 1 1 fffe",
        rsp_valid, sp_push, sp);
    end
    @(posedge clk);
    #1;
    ack_dly = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    xact(1'b0, 16'h1234);
    ack_dly   = 100;
    req_valid = 1'b1;
    req_op    = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL midrst_pop got req %b we %b addr %h want 1 0 ffff",
        mem_req, mem_we, mem_addr);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({req_ready, mem_req, rsp_valid, sp_pop, empty} !== 5'b10001 ||
        sp !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL midrst_after got rdy/req/rv/spop/empty %b sp %h want 10001 ffff",
        {req_ready, mem_req, rsp_valid, sp_pop, empty}, sp);
    end
    ack_dly = 0;
    xact(1'b0, 16'h5678);
    n_cmp++;
    if (o_spush !== 1'b1 || o_nv !== 16'hFFFE || o_addr1 !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL midrst_resume got spush %b nv %h addr %h want 1 fffe ffff",
        o_spush, o_nv, o_addr1);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 1'b0;
    req_wdata = 16'h0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    ack_dly   = 0;
    wait_cnt  = 0;
    test_reset();
    test_push_imm();
    test_push_pop();
    test_pop_empty();
    test_fill();
    test_ack_delay();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
